// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two prioritised write ports, busy scoreboard.
// Optional write-to-read forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_mp #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned SP_IDX  = 29,
    parameter int unsigned SP_INIT = 128
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] RDaddr_i,
    output logic [NUM_RD*DATA_W-1:0] RDdata_o,
    output logic [NUM_RD-1:0]        RDbusy_o,
    input  logic                     WAen_i,
    input  logic [ADDR_W-1:0]        WAaddr_i,
    input  logic [DATA_W-1:0]        WAdata_i,
    input  logic                     WBen_i,
    input  logic [ADDR_W-1:0]        WBaddr_i,
    input  logic [DATA_W-1:0]        WBdata_i,
    input  logic                     ISSUEen_i,
    input  logic [ADDR_W-1:0]        ISSUEaddr_i,
    output logic                     WRconflict_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              conflict_q;
    logic              conflict_d;

    logic wa_we;
    logic wb_we;
    logic issue_set;

    // Register 0 is hardwired: writes and issues aimed at it are dropped here.
    assign wa_we     = WAen_i && (WAaddr_i != '0);
    assign wb_we     = WBen_i && (WBaddr_i != '0);
    assign issue_set = ISSUEen_i && (ISSUEaddr_i != '0);

    // Next state: B is applied after A so it wins a collision; issue set beats commit clear.
    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        conflict_d = wa_we && wb_we && (WAaddr_i == WBaddr_i);
        if (wa_we) begin
            regs_d[WAaddr_i] = WAdata_i;
            busy_d[WAaddr_i] = 1'b0;
        end
        if (wb_we) begin
            regs_d[WBaddr_i] = WBdata_i;
            busy_d[WBaddr_i] = 1'b0;
        end
        if (issue_set) begin
            busy_d[ISSUEaddr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
            end
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign WRconflict_o = conflict_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;
`ifdef REG_FILE_BYPASS_EN
        logic              hit_a;
        logic              hit_b;
        logic              hit_issue;

        assign hit_a     = wa_we && (WAaddr_i == addr);
        assign hit_b     = wb_we && (WBaddr_i == addr);
        assign hit_issue = issue_set && (ISSUEaddr_i == addr);
`endif

        assign addr = RDaddr_i[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = regs_q[addr];
            busy = busy_q[addr];
`ifdef REG_FILE_BYPASS_EN
            if (hit_a) data = WAdata_i;
            if (hit_b) data = WBdata_i;
            // A committing producer already clears busy unless a new producer issues now.
            if ((hit_a || hit_b) && !hit_issue) busy = 1'b0;
`endif
            if (addr == '0) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign RDdata_o[k*DATA_W +: DATA_W] = data;
        assign RDbusy_o[k]                  = busy;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: directed stimulus queues expectations per cycle; a negedge monitor checks them.
module tb_reg_file_mp;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM_RD = 2;

    logic                     clk;
    logic                     rst_i;
    logic [NUM_RD*ADDR_W-1:0] RDaddr_i;
    logic [NUM_RD*DATA_W-1:0] RDdata_o;
    logic [NUM_RD-1:0]        RDbusy_o;
    logic                     WAen_i;
    logic [ADDR_W-1:0]        WAaddr_i;
    logic [DATA_W-1:0]        WAdata_i;
    logic                     WBen_i;
    logic [ADDR_W-1:0]        WBaddr_i;
    logic [DATA_W-1:0]        WBdata_i;
    logic                     ISSUEen_i;
    logic [ADDR_W-1:0]        ISSUEaddr_i;
    logic                     WRconflict_o;

    reg_file_mp dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .RDaddr_i     (RDaddr_i),
        .RDdata_o     (RDdata_o),
        .RDbusy_o     (RDbusy_o),
        .WAen_i       (WAen_i),
        .WAaddr_i     (WAaddr_i),
        .WAdata_i     (WAdata_i),
        .WBen_i       (WBen_i),
        .WBaddr_i     (WBaddr_i),
        .WBdata_i     (WBdata_i),
        .ISSUEen_i    (ISSUEen_i),
        .ISSUEaddr_i  (ISSUEaddr_i),
        .WRconflict_o (WRconflict_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle n spans from rising edge n to rising edge n+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;   // 0 read data, 1 busy, 2 conflict
        int          port;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    int errors = 0;
    int checks = 0;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            item_t       it;
            logic [31:0] act;
            it = sb.pop_front();
            case (it.kind)
                0:       act = RDdata_o[it.port*DATA_W +: DATA_W];
                1:       act = 32'(RDbusy_o[it.port]);
                default: act = 32'(WRconflict_o);
            endcase
            checks++;
            if (it.cyc != cyc || act !== it.exp) begin
                errors++;
                $display("FAIL %s (cycle %0d, observed in %0d): got 0x%08h expected 0x%08h",
                         it.name, it.cyc, cyc, act, it.exp);
            end
        end
    end

    task automatic push(input int kind, input int port, input logic [31:0] exp, input string name);
        item_t it;
        it.cyc  = cyc;
        it.kind = kind;
        it.port = port;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic exp_rd(input int k, input logic [31:0] v, input string n);
        push(0, k, v, n);
    endtask

    task automatic exp_busy(input int k, input logic v, input string n);
        push(1, k, 32'(v), n);
    endtask

    task automatic exp_conf(input logic v, input string n);
        push(2, 0, 32'(v), n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WAen_i    = 1'b0;
        WBen_i    = 1'b0;
        ISSUEen_i = 1'b0;
    endtask

    task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
        RDaddr_i[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic wr_a(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        WAen_i   = 1'b1;
        WAaddr_i = a;
        WAdata_i = d;
    endtask

    task automatic wr_b(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        WBen_i   = 1'b1;
        WBaddr_i = a;
        WBdata_i = d;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a);
        ISSUEen_i   = 1'b1;
        ISSUEaddr_i = a;
    endtask

    initial begin
        rst_i = 1'b0;
        RDaddr_i = '0;
        WAaddr_i = '0; WAdata_i = '0;
        WBaddr_i = '0; WBdata_i = '0;
        ISSUEaddr_i = '0;
        idle();

        // Reset cycle with a write that must be lost
        tick();
        wr_a(5'd5, 32'hFFFF_FFFF);
        tick();
        rst_i = 1'b1;
        idle();
        set_rd(0, 5'd5);
        set_rd(1, 5'd29);
        exp_rd(0, 32'h0, "rst_reg5");
        exp_rd(1, 32'd128, "rst_sp");
        exp_busy(0, 1'b0, "rst_busy0");
        exp_busy(1, 1'b0, "rst_busy1");
        exp_conf(1'b0, "rst_conf");
        #1;
        checks++;
        if (RDdata_o[DATA_W +: DATA_W] !== 32'd128) begin
            errors++;
            $display("FAIL direct rst_sp: got 0x%08h", RDdata_o[DATA_W +: DATA_W]);
        end

        // Write then read on all ports
        tick();
        wr_a(5'd7, 32'h1234_5678);
        set_rd(0, 5'd7);
        set_rd(1, 5'd7);
`ifdef REG_FILE_BYPASS_EN
        exp_rd(0, 32'h1234_5678, "wr_cycle_p0");
        exp_rd(1, 32'h1234_5678, "wr_cycle_p1");
`else
        exp_rd(0, 32'h0, "wr_cycle_p0");
        exp_rd(1, 32'h0, "wr_cycle_p1");
`endif
        tick();
        idle();
        exp_rd(0, 32'h1234_5678, "wr_next_p0");
        exp_rd(1, 32'h1234_5678, "wr_next_p1");
        #1;
        checks++;
        if (RDdata_o[0 +: DATA_W] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL direct wr_next: got 0x%08h", RDdata_o[0 +: DATA_W]);
        end

        // Register 0: issue, then dual write of the same address
        tick();
        issue(5'd0);
        set_rd(0, 5'd0);
        set_rd(1, 5'd0);
        tick();
        idle();
        wr_a(5'd0, 32'hDEAD_BEEF);
        wr_b(5'd0, 32'hDEAD_BEEF);
        exp_rd(0, 32'h0, "r0_wr_cycle");
        exp_busy(0, 1'b0, "r0_busy_after_issue");
        tick();
        idle();
        exp_rd(0, 32'h0, "r0_rd_p0");
        exp_rd(1, 32'h0, "r0_rd_p1");
        exp_busy(1, 1'b0, "r0_busy_p1");
        exp_conf(1'b0, "r0_no_conflict");
        tick();
        exp_conf(1'b0, "r0_no_conflict2");

        // Write collision on reg 9
        tick();
        wr_a(5'd9, 32'h0000_1111);
        wr_b(5'd9, 32'h0000_2222);
        set_rd(0, 5'd9);
        set_rd(1, 5'd9);
`ifdef REG_FILE_BYPASS_EN
        exp_rd(0, 32'h0000_2222, "col_fwd_b");
`else
        exp_rd(0, 32'h0, "col_pre");
`endif
        exp_conf(1'b0, "col_conf_pre");
        tick();
        idle();
        exp_rd(0, 32'h0000_2222, "col_data_p0");
        exp_rd(1, 32'h0000_2222, "col_data_p1");
        exp_conf(1'b1, "col_conf_pulse");
        #1;
        checks++;
        if (WRconflict_o !== 1'b1) begin
            errors++;
            $display("FAIL direct col_conf_pulse: got %b", WRconflict_o);
        end
        tick();
        exp_conf(1'b0, "col_conf_drop");

        // Scoreboard on reg 12
        tick();
        issue(5'd12);
        set_rd(0, 5'd12);
        set_rd(1, 5'd12);
        exp_busy(0, 1'b0, "sb_issue_cycle");
        tick();
        idle();
        exp_busy(0, 1'b1, "sb_busy_p0");
        exp_busy(1, 1'b1, "sb_busy_p1");
        #1;
        checks++;
        if (RDbusy_o !== 2'b11) begin
            errors++;
            $display("FAIL direct sb_busy: got %b", RDbusy_o);
        end
        tick();
        wr_b(5'd12, 32'h0000_00AA);
        issue(5'd12);
        exp_busy(0, 1'b1, "sb_commit_issue_cyc");
        tick();
        idle();
        exp_busy(0, 1'b1, "sb_set_wins");
        exp_rd(0, 32'h0000_00AA, "sb_b_data");
        tick();
        wr_a(5'd12, 32'h0000_00BB);
`ifdef REG_FILE_BYPASS_EN
        exp_busy(0, 1'b0, "sb_commit_cyc");
        exp_rd(1, 32'h0000_00BB, "sb_commit_data_cyc");
`else
        exp_busy(0, 1'b1, "sb_commit_cyc");
        exp_rd(1, 32'h0000_00AA, "sb_commit_data_cyc");
`endif
        tick();
        idle();
        exp_busy(0, 1'b0, "sb_cleared_p0");
        exp_busy(1, 1'b0, "sb_cleared_p1");
        exp_rd(0, 32'h0000_00BB, "sb_a_data");

        // Mid-operation reset with busy regs 3, 4 and a write to reg 3
        tick();
        issue(5'd3);
        tick();
        issue(5'd4);
        set_rd(0, 5'd3);
        set_rd(1, 5'd4);
        exp_busy(0, 1'b1, "mr_busy3");
        tick();
        idle();
        rst_i = 1'b0;
        wr_a(5'd3, 32'h0000_3333);
        exp_busy(1, 1'b1, "mr_busy4");
`ifndef REG_FILE_BYPASS_EN
        exp_busy(0, 1'b1, "mr_busy3_rstcyc");
`endif
        tick();
        rst_i = 1'b1;
        idle();
        set_rd(1, 5'd29);
        exp_rd(0, 32'h0, "mr_reg3");
        exp_rd(1, 32'd128, "mr_sp");
        exp_busy(0, 1'b0, "mr_busy3_clr");
        exp_conf(1'b0, "mr_conf");
        #1;
        checks++;
        if (RDdata_o[DATA_W +: DATA_W] !== 32'd128) begin
            errors++;
            $display("FAIL direct mr_sp: got 0x%08h", RDdata_o[DATA_W +: DATA_W]);
        end
        tick();
        set_rd(0, 5'd4);
        exp_busy(0, 1'b0, "mr_busy4_clr");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        while (sb.size() > 0) begin
            item_t it;
            it = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never observed, expected 0x%08h", it.name, it.exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
